// File: rtl/clk_div_bank_pkg.sv
// Shared definitions for the divider bank: lock FSM encoding, reset
// configuration defaults and the phase clamp helper.
package clk_div_bank_pkg;

    typedef enum logic [1:0] {
        LK_WAIT   = 2'd0,
        LK_LOCKED = 2'd1,
        LK_UPDATE = 2'd2
    } lock_state_e;

    localparam int DEF_RATIO_C = 8;
    localparam int DEF_DUTY_C  = 4;
    localparam int DEF_PHASE_C = 0;

    // A start offset at or beyond the period would never be reached, so it restarts at 0.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] ratio);
        if (phase < ratio) begin
            return phase;
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow configuration that is only
// adopted at a period boundary (or sync), and registered level/tick outputs.
module clk_div_ch
    import clk_div_bank_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int DEF_RATIO = DEF_RATIO_C,
    parameter int DEF_DUTY  = DEF_DUTY_C,
    parameter int DEF_PHASE = DEF_PHASE_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] cfg_ratio_i,
    input  logic [CNT_W-1:0] cfg_duty_i,
    input  logic [CNT_W-1:0] cfg_phase_i,
    output logic             pending_o,
    output logic             div_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] ratio_q, duty_q, phase_q, ratio_d, duty_d, phase_d;
    logic [CNT_W-1:0] sh_ratio_q, sh_duty_q, sh_phase_q, sh_ratio_d, sh_duty_d, sh_phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d, tick_q, tick_d;
    logic             wrap_s, apply_s;

    // Next-state: counter step, boundary apply of the shadow, shadow capture and outputs.
    always_comb begin
        ratio_d    = ratio_q;
        duty_d     = duty_q;
        phase_d    = phase_q;
        sh_ratio_d = sh_ratio_q;
        sh_duty_d  = sh_duty_q;
        sh_phase_d = sh_phase_q;
        pend_d     = pend_q;
        wrap_s     = (ratio_q == CNT_W'(0)) || (cnt_q == (ratio_q - CNT_W'(1)));
        apply_s    = pend_q && (wrap_s || sync_i);
        cnt_d      = wrap_s ? CNT_W'(0) : (cnt_q + CNT_W'(1));

        if (apply_s) begin
            ratio_d = sh_ratio_q;
            duty_d  = sh_duty_q;
            phase_d = sh_phase_q;
            pend_d  = 1'b0;
            cnt_d   = CNT_W'(clamp_phase(32'(sh_phase_q), 32'(sh_ratio_q)));
        end else if (sync_i) begin
            cnt_d = CNT_W'(clamp_phase(32'(phase_q), 32'(ratio_q)));
        end else begin
            cnt_d = cnt_d;
        end

        // wr_i is only raised while pend_q is low, so it never collides with an apply.
        if (wr_i) begin
            sh_ratio_d = cfg_ratio_i;
            sh_duty_d  = cfg_duty_i;
            sh_phase_d = cfg_phase_i;
            pend_d     = 1'b1;
        end else begin
            pend_d = pend_d;
        end

        div_d  = (ratio_q != CNT_W'(0)) && (cnt_q < duty_q);
        tick_d = (ratio_q != CNT_W'(0)) && (cnt_q == CNT_W'(0));
    end

    // Channel state registers; reset drops any shadow in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q    <= CNT_W'(DEF_RATIO);
            duty_q     <= CNT_W'(DEF_DUTY);
            phase_q    <= CNT_W'(DEF_PHASE);
            sh_ratio_q <= CNT_W'(DEF_RATIO);
            sh_duty_q  <= CNT_W'(DEF_DUTY);
            sh_phase_q <= CNT_W'(DEF_PHASE);
            pend_q     <= 1'b0;
            cnt_q      <= CNT_W'(0);
            div_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            ratio_q    <= ratio_d;
            duty_q     <= duty_d;
            phase_q    <= phase_d;
            sh_ratio_q <= sh_ratio_d;
            sh_duty_q  <= sh_duty_d;
            sh_phase_q <= sh_phase_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign div_o     = div_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers with a shared configuration port,
// global sync realignment and a lock indicator.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 10,
    parameter int DEF_RATIO = DEF_RATIO_C,
    parameter int DEF_DUTY  = DEF_DUTY_C,
    parameter int DEF_PHASE = DEF_PHASE_C,
    parameter int LOCK_DLY  = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_i,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_ratio,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] div_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic              lock_o
);

    localparam int LCNT_W = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;

    logic [NUM_CH-1:0] sel_s, wr_s, pend_s;
    lock_state_e       state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              lock_q, lock_d, lcnt_done_s;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            assign sel_s[i] = (cfg_ch == CH_W'(i));
            assign wr_s[i]  = cfg_valid && sel_s[i] && !pend_s[i];

            clk_div_ch #(
                .CNT_W     (CNT_W),
                .DEF_RATIO (DEF_RATIO),
                .DEF_DUTY  (DEF_DUTY),
                .DEF_PHASE (DEF_PHASE)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .sync_i      (sync_i),
                .wr_i        (wr_s[i]),
                .cfg_ratio_i (cfg_ratio),
                .cfg_duty_i  (cfg_duty),
                .cfg_phase_i (cfg_phase),
                .pending_o   (pend_s[i]),
                .div_o       (div_o[i]),
                .tick_o      (tick_o[i])
            );
        end
    endgenerate

    // A channel index with no matching select reads as ready and is dropped.
    assign cfg_ready   = ~|(sel_s & pend_s);
    assign lcnt_done_s = (int'(lcnt_q) >= (LOCK_DLY - 1));

    // Lock FSM next state: settle delay, then track outstanding updates.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        if (sync_i) begin
            state_d = LK_WAIT;
            lcnt_d  = LCNT_W'(0);
        end else begin
            case (state_q)
                LK_WAIT: begin
                    if (lcnt_done_s) begin
                        state_d = LK_LOCKED;
                        lcnt_d  = LCNT_W'(0);
                    end else begin
                        lcnt_d = lcnt_q + LCNT_W'(1);
                    end
                end
                LK_LOCKED: begin
                    if (|pend_s) begin
                        state_d = LK_UPDATE;
                    end else begin
                        state_d = LK_LOCKED;
                    end
                end
                LK_UPDATE: begin
                    if (~|pend_s) begin
                        state_d = LK_LOCKED;
                    end else begin
                        state_d = LK_UPDATE;
                    end
                end
                default: begin
                    state_d = LK_WAIT;
                    lcnt_d  = LCNT_W'(0);
                end
            endcase
        end
        lock_d = (state_d == LK_LOCKED);
    end

    // Lock FSM registers; lock_o is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LK_WAIT;
            lcnt_q  <= LCNT_W'(0);
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            lock_q  <= lock_d;
        end
    end

    assign lock_o = lock_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised plus directed bench for clk_div_bank; a timestamp-based
// reference model feeds a scoreboard drained by an independent monitor.
module tb_clk_div_bank;

    localparam int NCH = 3;
    localparam int CW  = 10;
    localparam int LD  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sync_i = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [1:0]     cfg_ch = 2'd0;
    logic [CW-1:0]  cfg_ratio = '0, cfg_duty = '0, cfg_phase = '0;
    logic           cfg_ready;
    logic [NCH-1:0] div_o, tick_o;
    logic           lock_o;

    clk_div_bank #(
        .NUM_CH(NCH), .CNT_W(CW), .DEF_RATIO(8), .DEF_DUTY(4), .DEF_PHASE(0), .LOCK_DLY(LD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync_i(sync_i), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
        .div_o(div_o), .tick_o(tick_o), .lock_o(lock_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] div;
        logic [NCH-1:0] tick;
        logic           lock;
        logic           ready;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each channel's position is derived from the cycle
    // number relative to the last realignment, not from a stored counter.
    int m_ratio[NCH], m_duty[NCH], m_phase[NCH];
    int s_ratio[NCH], s_duty[NCH], s_phase[NCH];
    bit m_pend[NCH];
    int m_anchor[NCH], m_start[NCH];
    int cyc, wait_end;
    logic [NCH-1:0] m_div, m_tick;
    logic m_lock;

    function automatic int pos(int c);
        if (m_ratio[c] == 0) return 0;
        return (m_start[c] + (cyc - m_anchor[c])) % m_ratio[c];
    endfunction

    function automatic bit exp_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ratio[c] = 8; m_duty[c] = 4; m_phase[c] = 0;
            s_ratio[c] = 8; s_duty[c] = 4; s_phase[c] = 0;
            m_pend[c] = 1'b0; m_anchor[c] = 0; m_start[c] = 0;
        end
        cyc = 0; wait_end = LD;
        m_div = '0; m_tick = '0; m_lock = 1'b0;
    endtask

    task automatic model_edge();
        bit anyp;
        anyp = 1'b0;
        for (int c = 0; c < NCH; c++) anyp |= m_pend[c];
        for (int c = 0; c < NCH; c++) begin
            int  p;
            bit  wrap, xfer, apply;
            p        = pos(c);
            wrap     = (m_ratio[c] == 0) || (p == m_ratio[c] - 1);
            m_div[c]  = (m_ratio[c] != 0) && (p < m_duty[c]);
            m_tick[c] = (m_ratio[c] != 0) && (p == 0);
            xfer  = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
            apply = m_pend[c] && (wrap || sync_i);
            if (apply) begin
                m_ratio[c] = s_ratio[c]; m_duty[c] = s_duty[c]; m_phase[c] = s_phase[c];
                m_pend[c] = 1'b0;
            end
            if (apply || sync_i) begin
                m_anchor[c] = cyc + 1;
                m_start[c]  = (m_phase[c] < m_ratio[c]) ? m_phase[c] : 0;
            end
            if (xfer) begin
                s_ratio[c] = int'(cfg_ratio); s_duty[c] = int'(cfg_duty); s_phase[c] = int'(cfg_phase);
                m_pend[c] = 1'b1;
            end
        end
        cyc++;
        if (sync_i) begin
            wait_end = cyc + LD;
            m_lock   = 1'b0;
        end else begin
            m_lock = (cyc == wait_end) || ((cyc > wait_end) && !anyp);
        end
    endtask

    // One clock of stimulus: drive, record expectation, advance the model at the edge.
    task automatic step(input bit v, input int ch, input int r, input int d, input int p,
                        input bit s, input bit rn);
        exp_t e;
        cfg_valid = v; cfg_ch = ch[1:0];
        cfg_ratio = r[CW-1:0]; cfg_duty = d[CW-1:0]; cfg_phase = p[CW-1:0];
        sync_i = s; rst_n = rn;
        if (!rn) model_reset();
        e.div = m_div; e.tick = m_tick; e.lock = m_lock; e.ready = exp_ready();
        exp_q.push_back(e);
        @(posedge clk);
        if (rn) model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    // Hold a write until the channel accepts it (stall on a pending update).
    task automatic write_hold(input int ch, input int r, input int d, input int p);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            done = (ch >= NCH) || !m_pend[ch];
            step(1'b1, ch, r, d, p, 1'b0, 1'b1);
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL write_hold ch%0d: not accepted within 64 cycles, required accept", ch);
        end
    endtask

    // Issue a write exactly on the channel's wrap edge.
    task automatic wrap_write(input int ch, input int r, input int d, input int p);
        for (int k = 0; k < 64; k++) begin
            if (m_ratio[ch] != 0 && !m_pend[ch] && pos(ch) == m_ratio[ch] - 1) begin
                step(1'b1, ch, r, d, p, 1'b0, 1'b1);
                return;
            end
            idle(1);
        end
        vectors++; miscompares++;
        $display("FAIL wrap_write ch%0d: no wrap edge within 64 cycles, required one", ch);
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (div_o !== e.div || tick_o !== e.tick || lock_o !== e.lock || cfg_ready !== e.ready) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: div=%b/%b tick=%b/%b lock=%b/%b ready=%b/%b (got/required)",
                             $time, div_o, e.div, tick_o, e.tick, lock_o, e.lock, cfg_ready, e.ready);
                end
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        repeat (3) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(40);
        // Mid-period reconfiguration of ch1, then a back-to-back write that must stall.
        idle(3);
        write_hold(1, 5, 2, 0);
        write_hold(1, 6, 3, 1);
        idle(30);
        // Phase alignment and sync realignment.
        write_hold(0, 8, 4, 0);
        write_hold(2, 8, 4, 2);
        idle(20);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(30);
        // Extremes: stopped channel, ratio 1, duty beyond ratio, phase beyond ratio.
        write_hold(0, 0, 4, 0);
        write_hold(1, 1, 1, 0);
        write_hold(2, 8, 9, 12);
        idle(30);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(20);
        // Write landing on the wrap edge, plus an out-of-range channel index.
        write_hold(2, 8, 4, 0);
        idle(12);
        wrap_write(2, 6, 3, 0);
        idle(3);
        write_hold(3, 2, 1, 0);
        idle(20);
        // Reset while an update is pending.
        write_hold(1, 7, 3, 2);
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(30);
        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit v, s, rn;
            v  = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 63) == 0);
            rn = ($urandom_range(0, 499) != 0);
            step(v, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14),
                 $urandom_range(0, 14), s, rn);
        end
        idle(2);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
